// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop recovery from an
// asynchronous serial line, with a registered data word, done strobe,
// stop-bit error flag and busy indication.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronised rx
// START | counting to the middle of the start bit to confirm it
// DATA  | sampling DBIT data bits at their centres, LSB first
// STOP  | waiting out the stop period, then delivering the word
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [4:0] S_MID      = 5'd7;
    localparam logic [4:0] S_BIT_LAST = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST     = 3'(DBIT - 1);

    state_t     state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       rx_meta_q;
    logic       rx_sync_q;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State register together with the counters and output registers it steers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            dout_q  <= 8'd0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: everything except the start detect advances on s_tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    s_d     = 5'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = 5'd0;
                            n_d     = 3'd0;
                            b_d     = 8'd0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = 5'd0;
                        b_d = {rx_sync_q, b_q[7:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = IDLE;
                        // Short words are shifted in from the top; right-align them.
                        dout_d  = b_q >> (8 - DBIT);
                        ferr_d  = ~rx_sync_q;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: busy follows the current state one cycle later.
    always_comb begin
        busy_d = (state_q != IDLE);
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = busy_q;

endmodule
